// File: rtl/button_conditioner.sv
// Pushbutton front end: 2-flop sync, debounce, press / delayed-auto-repeat pulses, left/right conflict.
// Define BUTTON_AUTOREPEAT_EN to build the DELAY/REPEAT auto-repeat path; otherwise one pulse per press.
module button_lane #(
    parameter int DEBOUNCE_CYC = 3,
    parameter int DAS_DELAY    = 10,
    parameter int ARR_PERIOD   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic en,
    input  logic hold,
    output logic held_nxt,
    output logic held,
    output logic press
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int REP_MAX = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    logic [REP_W-1:0] rep;
`else
    typedef enum logic {IDLE, HELD} state_t;
    logic unused_cfg;
    assign unused_cfg = (DAS_DELAY > 0) ^ (ARR_PERIOD > 0);
`endif

    state_t          state;
    logic [1:0]      sync;
    logic [DB_W-1:0] db_cnt, db_cnt_nxt;
    logic            rise;

    // Next debounced level is exported so the pulse logic reacts on the same edge held rises.
    always_comb begin
        held_nxt   = held;
        db_cnt_nxt = '0;
        if (sync[1] != held) begin
            if (int'(db_cnt) + 1 >= DEBOUNCE_CYC) held_nxt = ~held;
            else                                  db_cnt_nxt = db_cnt + 1'b1;
        end
    end

    assign rise = held_nxt & ~held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            db_cnt <= '0;
            held   <= 1'b0;
            press  <= 1'b0;
            state  <= IDLE;
`ifdef BUTTON_AUTOREPEAT_EN
            rep    <= '0;
`endif
        end else begin
            sync   <= {sync[0], btn};
            db_cnt <= db_cnt_nxt;
            held   <= held_nxt;
            press  <= 1'b0;
            if (!held_nxt || !en) begin
                state <= IDLE;
`ifdef BUTTON_AUTOREPEAT_EN
                rep   <= '0;
`endif
            end else if (hold) begin
                // Parked with a zeroed count; an IDLE lane left over from enable-off stays IDLE.
                if (state != IDLE || rise) begin
`ifdef BUTTON_AUTOREPEAT_EN
                    state <= DELAY;
                    rep   <= '0;
`else
                    state <= HELD;
`endif
                end
            end else begin
                case (state)
                    IDLE: if (rise) begin
                        press <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                        state <= DELAY;
`else
                        state <= HELD;
`endif
                    end
`ifdef BUTTON_AUTOREPEAT_EN
                    DELAY: if (int'(rep) + 1 >= DAS_DELAY) begin
                        press <= 1'b1;
                        rep   <= '0;
                        state <= REPEAT;
                    end else begin
                        rep <= rep + 1'b1;
                    end
                    REPEAT: if (int'(rep) + 1 >= ARR_PERIOD) begin
                        press <= 1'b1;
                        rep   <= '0;
                    end else begin
                        rep <= rep + 1'b1;
                    end
`else
                    HELD: state <= HELD;
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

module button_conditioner #(
    parameter int N_BTN        = 4,
    parameter int DEBOUNCE_CYC = 3,
    parameter int DAS_DELAY    = 10,
    parameter int ARR_PERIOD   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_i,
    input  logic             enable_i,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] held_o
);
    logic [N_BTN-1:0] held_nxt;
    logic             lateral_hold;

    // Covers the cycle both rise and the cycle one of them drops, so the survivor restarts its delay.
    assign lateral_hold = (held_nxt[0] & held_nxt[1]) | (held_o[0] & held_o[1]);

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        button_lane #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .DAS_DELAY   (DAS_DELAY),
            .ARR_PERIOD  (ARR_PERIOD)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn     (btn_i[i]),
            .en      (enable_i),
            .hold    ((i < 2) ? lateral_hold : 1'b0),
            .held_nxt(held_nxt[i]),
            .held    (held_o[i]),
            .press   (press_o[i])
        );
    end
endmodule
